axi_apb_bridge: RTL and testbench
=================================

AXI_APB_BRIDGE -- requirements
Module: axi_apb_bridge

Interface
REQ-001 SHALL have parameter: SLVERR_RESP, default 2'b10, AXI response code returned when out_pslverr=1.
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: awvalid  input  1  AXI4-lite write-address valid.
REQ-005 SHALL have port: awready  output  1  write-address accept.
REQ-006 SHALL have port: awaddr  input  32  write byte address.
REQ-007 SHALL have port: wvalid  input  1  write-data valid.
REQ-008 SHALL have port: wready  output  1  write-data accept.
REQ-009 SHALL have port: wdata  input  32  write data.
REQ-010 SHALL have port: wstrb  input  4  write byte strobes.
REQ-011 SHALL have port: bvalid  output  1  write response valid.
REQ-012 SHALL have port: bready  input  1  write response accept.
REQ-013 SHALL have port: bresp  output  2  write response code.
REQ-014 SHALL have port: arvalid  input  1  read-address valid.
REQ-015 SHALL have port: arready  output  1  read-address accept.
REQ-016 SHALL have port: araddr  input  32  read byte address.
REQ-017 SHALL have port: rvalid  output  1  read data valid.
REQ-018 SHALL have port: rready  input  1  read data accept.
REQ-019 SHALL have port: rdata  output  32  read data.
REQ-020 SHALL have port: rresp  output  2  read response code.
REQ-021 SHALL have port: out_paddr  output  32  APB address, passed unmodified (no alignment).
REQ-022 SHALL have port: out_psel  output  1  APB select.
REQ-023 SHALL have port: out_penable  output  1  APB enable.
REQ-024 SHALL have port: out_pprot  output  3  APB protection, constant 3'b000.
REQ-025 SHALL have port: out_pwrite  output  1  APB direction, 1=write.
REQ-026 SHALL have port: out_pwdata  output  32  APB write data.
REQ-027 SHALL have port: out_pstrb  output  4  APB strobes; 4'b0000 on reads.
REQ-028 SHALL have port: out_pready  input  1  APB completion.
REQ-029 SHALL have port: out_prdata  input  32  APB read data.
REQ-030 SHALL have port: out_pslverr  input  1  APB error, sampled with out_pready.

Function
REQ-031 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; exactly one APB transfer in flight.
REQ-032 SHALL hold AW and W in separate one-entry registers; awready=!aw_full, wready=!w_full, in any state; a write is pending only when both are full.
REQ-033 SHALL, in IDLE, grant read (arvalid) or pending write; when both are present, round-robin against the last-served type; after reset, last-served=write, so read wins the first tie.
REQ-034 SHALL assert arready only in IDLE in the cycle a read is granted; araddr is captured that cycle; state goes to SETUP next cycle.
REQ-035 SHALL, for a write grant, go to SETUP next cycle; AW/W registers stay full until the response handshake.
REQ-036 SHALL drive SETUP: out_psel=1, out_penable=0, for exactly one cycle, then go to ACCESS.
REQ-037 SHALL drive ACCESS: out_psel=1, out_penable=1, addr/write/wdata/strb stable until out_pready=1; no timeout.
REQ-038 SHALL, on an ACCESS cycle with out_pready=1, capture out_prdata and out_pslverr, go to RESP, and drop out_psel/out_penable next cycle.
REQ-039 SHALL drive RESP: rvalid (read) or bvalid (write) =1; resp = SLVERR_RESP if pslverr else 2'b00; hold until rready/bready; then clear AW/W (write) and go to IDLE.
REQ-040 SHALL give a zero-wait-state read latency of arvalid&arready at cycle 0, SETUP at 1, ACCESS at 2, rvalid at 3.
REQ-041 SHALL start no new APB transfer while in RESP, even when AW, W or AR arrives.
REQ-042 SHALL hold out_psel, out_penable, out_pwrite and out_pstrb at 0 outside SETUP/ACCESS.

Reset
REQ-043 SHALL, on resetn low at any time (including mid-ACCESS), immediately enter IDLE, empty the AW/W registers, and drive every output to 0 except awready=wready=1.

Verification
REQ-044 SHALL cover read 0x30000010 with out_pready one cycle after SETUP and prdata 0xDEADBEEF -> rvalid at cycle 3, rdata 0xDEADBEEF, rresp 2'b00.
REQ-045 SHALL cover W arriving 3 cycles before AW (addr 0x10000004, data 0x55, strb 4'b0001) -> no APB activity until AW arrives; then pwrite=1, pstrb 4'b0001; bresp 2'b00.
REQ-046 SHALL cover arvalid and a full write pair presented together twice -> first read, then write, alternating.
REQ-047 SHALL cover pslverr=1 on a read with 5 wait states -> out_psel held 6 ACCESS cycles, rresp 2'b10.
REQ-048 SHALL cover rready held low 4 cycles with a new arvalid -> rvalid stays, arready=0, no out_psel until the handshake.
REQ-049 SHALL cover resetn asserted mid-ACCESS -> out_psel=0 and rvalid=0 immediately, state IDLE after release.

Source files
------------

// File: rtl/axi_apb_bridge_if.sv
// Bus bundle for the AXI4-lite to APB bridge: AXI4-lite slave channels plus the APB requester side.
// Every channel uses valid/ready: a beat transfers on the rising edge where both are high, and valid may not wait on ready.
interface axi_apb_bridge_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, rready,
    input  out_pready, out_prdata, out_pslverr,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, rready,
    output out_pready, out_prdata, out_pslverr,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb
  );
endinterface

// File: rtl/axi_apb_bridge.sv
// AXI4-lite to APB bridge: one APB transfer in flight, reads and writes arbitrated round-robin.
// dbg_state exposes the FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP).
module axi_apb_bridge #(
  parameter logic [1:0] SLVERR_RESP = 2'b10
) (
  input  logic             clk,
  input  logic             resetn,
  axi_apb_bridge_if.slave  bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        aw_full_q, aw_full_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic        w_full_q, w_full_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        last_write_q, last_write_d;
  logic        cur_write_q, cur_write_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        rvalid_q, rvalid_d;
  logic        bvalid_q, bvalid_d;

  logic write_pending;
  logic grant_rd;
  logic grant_wr;
  logic resp_done;
  logic [1:0] apb_resp;

  assign write_pending = aw_full_q && w_full_q;
  // On a tie the type not served last wins; last_write_q resets to 1 so the first tie goes to the read.
  assign grant_rd  = (state_q == IDLE) && bus.arvalid && (!write_pending || last_write_q);
  assign grant_wr  = (state_q == IDLE) && write_pending && !grant_rd;
  assign resp_done = (rvalid_q && bus.rready) || (bvalid_q && bus.bready);
  assign apb_resp  = bus.out_pslverr ? SLVERR_RESP : 2'b00;

  always_comb begin
    state_d      = state_q;
    aw_full_d    = aw_full_q;
    aw_addr_d    = aw_addr_q;
    w_full_d     = w_full_q;
    w_data_d     = w_data_q;
    w_strb_d     = w_strb_q;
    last_write_d = last_write_q;
    cur_write_d  = cur_write_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    bvalid_d     = bvalid_q;

    if (bus.awvalid && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = bus.awaddr;
    end
    if (bus.wvalid && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = bus.wdata;
      w_strb_d = bus.wstrb;
    end

    case (state_q)
      IDLE: begin
        if (grant_rd) begin
          state_d      = SETUP;
          psel_d       = 1'b1;
          pwrite_d     = 1'b0;
          paddr_d      = bus.araddr;
          pwdata_d     = 32'h0;
          pstrb_d      = 4'b0000;
          cur_write_d  = 1'b0;
          last_write_d = 1'b0;
        end else if (grant_wr) begin
          state_d      = SETUP;
          psel_d       = 1'b1;
          pwrite_d     = 1'b1;
          paddr_d      = aw_addr_q;
          pwdata_d     = w_data_q;
          pstrb_d      = w_strb_q;
          cur_write_d  = 1'b1;
          last_write_d = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.out_pready) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          pstrb_d   = 4'b0000;
          if (cur_write_q) begin
            bvalid_d = 1'b1;
            bresp_d  = apb_resp;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = bus.out_prdata;
            rresp_d  = apb_resp;
          end
        end
      end
      RESP: begin
        // AW/W stay occupied through the response so a second write cannot slip in behind it.
        if (resp_done) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
          bvalid_d = 1'b0;
          if (cur_write_q) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      aw_full_q    <= 1'b0;
      aw_addr_q    <= 32'h0;
      w_full_q     <= 1'b0;
      w_data_q     <= 32'h0;
      w_strb_q     <= 4'b0000;
      last_write_q <= 1'b1;
      cur_write_q  <= 1'b0;
      paddr_q      <= 32'h0;
      pwdata_q     <= 32'h0;
      pstrb_q      <= 4'b0000;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      rdata_q      <= 32'h0;
      rresp_q      <= 2'b00;
      bresp_q      <= 2'b00;
      rvalid_q     <= 1'b0;
      bvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      aw_full_q    <= aw_full_d;
      aw_addr_q    <= aw_addr_d;
      w_full_q     <= w_full_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      last_write_q <= last_write_d;
      cur_write_q  <= cur_write_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      bvalid_q     <= bvalid_d;
    end
  end

  // arready is the only combinational output; gating with resetn keeps it low while reset is held.
  assign bus.arready     = resetn && grant_rd;
  assign bus.awready     = !aw_full_q;
  assign bus.wready      = !w_full_q;
  assign bus.bvalid      = bvalid_q;
  assign bus.bresp       = bresp_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rresp       = rresp_q;
  assign bus.out_paddr   = paddr_q;
  assign bus.out_psel    = psel_q;
  assign bus.out_penable = penable_q;
  assign bus.out_pprot   = 3'b000;
  assign bus.out_pwrite  = pwrite_q;
  assign bus.out_pwdata  = pwdata_q;
  assign bus.out_pstrb   = pstrb_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_axi_apb_bridge.sv
// Directed bench for axi_apb_bridge: APB responder, response scoreboards and cycle-accurate checks.
module tb_axi_apb_bridge;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] dbg_state;

  axi_apb_bridge_if bus();

  axi_apb_bridge #(.SLVERR_RESP(2'b10)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [71:0] apb_exp_q[$];
  logic [33:0] rd_exp_q[$];
  logic [1:0]  wr_exp_q[$];

  int          wait_cfg = 0;
  logic        err_cfg  = 1'b0;
  logic        fix_cfg  = 1'b0;
  logic [31:0] fix_data = 32'h0;
  int          acc_cnt  = 0;
  int          acc_seen = 0;
  logic        quiet;
  logic        ok5;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within cycle budget", name);
  endtask

  // APB responder and transfer monitor: completes after wait_cfg wait states.
  always @(negedge clk) begin
    bus.out_pready  = 1'b0;
    bus.out_pslverr = 1'b0;
    if (resetn && bus.out_psel && bus.out_penable) begin
      acc_cnt++;
      if (acc_cnt > wait_cfg) begin
        bus.out_pready  = 1'b1;
        bus.out_pslverr = err_cfg;
        bus.out_prdata  = fix_cfg ? fix_data : {bus.out_paddr[15:0], ~bus.out_paddr[15:0]};
        acc_seen = acc_cnt;
        acc_cnt  = 0;
        if (apb_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL apb_unexpected: got transfer addr %h want none", bus.out_paddr);
        end else begin
          check("apb_xfer",
                {bus.out_pwrite, bus.out_paddr, (bus.out_pwrite ? bus.out_pwdata : 32'h0),
                 bus.out_pstrb, bus.out_pprot},
                apb_exp_q.pop_front());
        end
      end
    end else begin
      acc_cnt = 0;
    end
  end

  // AXI response monitor.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.rvalid && bus.rready) begin
        if (rd_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL r_unexpected: got %h want none", bus.rdata);
        end else begin
          check("r_beat", {bus.rdata, bus.rresp}, rd_exp_q.pop_front());
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (wr_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected: got %h want none", bus.bresp);
        end else begin
          check("b_beat", bus.bresp, wr_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!bus.arready) fail_now("ar_handshake");
    @(posedge clk);
    #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    @(negedge clk);
    while (!bus.awready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!bus.awready) fail_now("aw_handshake");
    @(posedge clk);
    #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    @(negedge clk);
    while (!bus.wready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!bus.wready) fail_now("w_handshake");
    @(posedge clk);
    #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_rvalid(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.rvalid && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!bus.rvalid) fail_now(name);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((apb_exp_q.size() != 0 || rd_exp_q.size() != 0 || wr_exp_q.size() != 0 ||
            dbg_state != 2'd0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail_now(name);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.awvalid = 1'b0;  bus.awaddr = 32'h0;
    bus.wvalid  = 1'b0;  bus.wdata  = 32'h0;  bus.wstrb = 4'h0;
    bus.arvalid = 1'b1;  bus.araddr = 32'h0;
    bus.bready  = 1'b1;  bus.rready = 1'b1;
    bus.out_pready = 1'b0;  bus.out_prdata = 32'h0;  bus.out_pslverr = 1'b0;

    // Reset values, with arvalid high to make sure arready stays low in reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                     bus.out_psel, bus.out_penable, bus.out_pwrite}, 8'hC0);
    check("rst_codes", {bus.out_pstrb, bus.out_pprot, bus.bresp, bus.rresp}, 11'h0);
    check("rst_data", {bus.rdata, bus.out_paddr}, 64'h0);
    check("rst_state", dbg_state, 2'd0);
    bus.arvalid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Zero-wait read: handshake cycle 0, SETUP 1, ACCESS 2, rvalid 3.
    fix_cfg  = 1'b1;
    fix_data = 32'hDEADBEEF;
    apb_exp_q.push_back({1'b0, 32'h30000010, 32'h0, 4'h0, 3'h0});
    rd_exp_q.push_back({32'hDEADBEEF, 2'b00});
    bus.araddr  = 32'h30000010;
    bus.arvalid = 1'b1;
    @(negedge clk);
    check("t1_arready_c0", bus.arready, 1'b1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    check("t1_setup_c1", {bus.out_psel, bus.out_penable}, 2'b10);
    @(negedge clk);
    check("t1_access_c2", {bus.out_psel, bus.out_penable}, 2'b11);
    @(negedge clk);
    check("t1_rvalid_c3", bus.rvalid, 1'b1);
    drain("t1_drain");
    fix_cfg = 1'b0;

    // W three cycles ahead of AW: nothing on APB until AW lands.
    apb_exp_q.push_back({1'b1, 32'h10000004, 32'h00000055, 4'b0001, 3'h0});
    wr_exp_q.push_back(2'b00);
    send_w(32'h00000055, 4'b0001);
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_psel) quiet = 1'b0;
    end
    check("t2_no_apb", quiet, 1'b1);
    @(posedge clk); #1;
    send_aw(32'h10000004);
    drain("t2_drain");

    // Write with slave error.
    err_cfg = 1'b1;
    apb_exp_q.push_back({1'b1, 32'h10000008, 32'hA5A51234, 4'b1111, 3'h0});
    wr_exp_q.push_back(2'b10);
    fork
      send_aw(32'h10000008);
      send_w(32'hA5A51234, 4'b1111);
    join
    drain("t3_drain");
    err_cfg = 1'b0;

    // Read/write ties alternate: R0, W1, R1, W2, R2.
    apb_exp_q.push_back({1'b0, 32'h20000100, 32'h0, 4'h0, 3'h0});
    apb_exp_q.push_back({1'b1, 32'h10000010, 32'h11223344, 4'b1111, 3'h0});
    apb_exp_q.push_back({1'b0, 32'h20000200, 32'h0, 4'h0, 3'h0});
    apb_exp_q.push_back({1'b1, 32'h10000020, 32'h0000CAFE, 4'b1100, 3'h0});
    apb_exp_q.push_back({1'b0, 32'h20000300, 32'h0, 4'h0, 3'h0});
    rd_exp_q.push_back({32'h0100FEFF, 2'b00});
    rd_exp_q.push_back({32'h0200FDFF, 2'b00});
    rd_exp_q.push_back({32'h0300FCFF, 2'b00});
    wr_exp_q.push_back(2'b00);
    wr_exp_q.push_back(2'b00);
    bus.rready = 1'b0;
    send_ar(32'h20000100);
    fork
      send_aw(32'h10000010);
      send_w(32'h11223344, 4'b1111);
    join
    fork
      send_ar(32'h20000200);
      begin
        wait_rvalid("t4_rvalid");
        repeat (2) @(posedge clk);
        #1;
        bus.rready = 1'b1;
      end
    join
    fork
      send_aw(32'h10000020);
      send_w(32'h0000CAFE, 4'b1100);
      send_ar(32'h20000300);
    join
    drain("t4_drain");

    // Read with five wait states and slave error.
    wait_cfg = 5;
    err_cfg  = 1'b1;
    apb_exp_q.push_back({1'b0, 32'h40000008, 32'h0, 4'h0, 3'h0});
    rd_exp_q.push_back({32'h0008FFF7, 2'b10});
    send_ar(32'h40000008);
    drain("t5_drain");
    check("t5_access_cycles", acc_seen, 6);
    wait_cfg = 0;
    err_cfg  = 1'b0;

    // rready low for four cycles with a new arvalid waiting.
    apb_exp_q.push_back({1'b0, 32'h20000400, 32'h0, 4'h0, 3'h0});
    apb_exp_q.push_back({1'b0, 32'h20000500, 32'h0, 4'h0, 3'h0});
    rd_exp_q.push_back({32'h0400FBFF, 2'b00});
    rd_exp_q.push_back({32'h0500FAFF, 2'b00});
    bus.rready = 1'b0;
    send_ar(32'h20000400);
    wait_rvalid("t6_rvalid");
    @(posedge clk); #1;
    fork
      send_ar(32'h20000500);
      begin
        ok5 = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (!bus.rvalid || bus.arready || bus.out_psel) ok5 = 1'b0;
        end
        check("t6_hold", ok5, 1'b1);
        @(posedge clk); #1;
        bus.rready = 1'b1;
      end
    join
    drain("t6_drain");

    // Reset asserted in the middle of an ACCESS phase.
    wait_cfg = 10;
    send_ar(32'h20000600);
    begin
      int n = 0;
      @(negedge clk);
      while (!(bus.out_psel && bus.out_penable) && n < 50) begin
        n++;
        @(negedge clk);
      end
      if (!(bus.out_psel && bus.out_penable)) fail_now("t7_access");
    end
    #2;
    resetn = 1'b0;
    #1;
    check("t7_rst_apb", {bus.out_psel, bus.out_penable, bus.out_pwrite, bus.rvalid, bus.arready}, 5'b0);
    check("t7_rst_ready", {bus.awready, bus.wready}, 2'b11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn   = 1'b1;
    wait_cfg = 0;
    @(negedge clk);
    check("t7_idle", {dbg_state, bus.out_psel}, 3'b000);
    @(posedge clk); #1;
    apb_exp_q.push_back({1'b0, 32'h20000700, 32'h0, 4'h0, 3'h0});
    rd_exp_q.push_back({32'h0700F8FF, 2'b00});
    send_ar(32'h20000700);
    drain("t7_drain");

    check("queues_empty", apb_exp_q.size() + rd_exp_q.size() + wr_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
